mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 boot_done  in  1  loader finished initial program load; sampled only in BOOT.
REQ-006 cpu_req / cpu_we  in  1 / 1  CPU access request / write-enable.
REQ-007 cpu_addr / cpu_wdata  in  ADDR_WIDTH / DATA_WIDTH  CPU address / write data.
REQ-008 cpu_gnt  out  1  CPU access accepted this cycle.
REQ-009 cpu_rdata / cpu_rvalid  out  DATA_WIDTH / 1  CPU read data / read-data-valid.
REQ-010 ld_req / ld_we / ld_lock  in  1 / 1 / 1  loader request / write-enable / exclusive-ownership request.
REQ-011 ld_addr / ld_wdata  in  ADDR_WIDTH / DATA_WIDTH  loader address / write data.
REQ-012 ld_gnt / ld_rdata / ld_rvalid  out  1 / DATA_WIDTH / 1  loader grant / read data / read-valid.
REQ-013 ram_en / ram_we  out  1 / 1  single-port RAM enable / write-enable.
REQ-014 ram_addr / ram_wdata  out  ADDR_WIDTH / DATA_WIDTH  RAM address / write data.
REQ-015 ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read command.
REQ-016 cpu_hold  out  1  CPU must stay stalled (asserted in BOOT and LOCK).
REQ-017 arb_state  out  2  current FSM state: 00 BOOT, 01 RUN, 10 LOCK.
REQ-018 stall_cnt  out  16  saturating count of cycles with cpu_req=1 and cpu_gnt=0.

Function
REQ-019 Grants SHALL be combinational from registered state and current requests; at most one of cpu_gnt/ld_gnt high per cycle.
REQ-020 Requester SHALL hold req/we/addr/wdata stable until its gnt; a transaction completes in the gnt cycle.
REQ-021 BOOT: ld_gnt = ld_req; cpu_gnt = 0; cpu_hold = 1; boot_done = 1 at an edge -> RUN next cycle.
REQ-022 RUN: single requester granted immediately; both requesting -> grant the requester not granted last (last_owner register).
REQ-023 RUN: ld_gnt=1 with ld_lock=1 -> LOCK next cycle; cpu_hold = 0 in RUN.
REQ-024 LOCK: only loader granted; cpu_hold = 1; ld_lock = 0 at an edge -> RUN next cycle, last_owner = loader.
REQ-025 ram_en = cpu_gnt | ld_gnt; ram_we/addr/wdata muxed from granted requester; with no grant all RAM outputs = 0.
REQ-026 Granted read (we=0) SHALL record owner; next cycle that owner's rvalid = 1 and rdata = ram_rdata.
REQ-027 rdata SHALL be 0 whenever its rvalid = 0; writes never produce rvalid.
REQ-028 Back-to-back reads SHALL be pipelined: one grant and one rvalid per cycle, no bubble.
REQ-029 boot_done ignored outside BOOT; ld_lock ignored in BOOT and when ld_gnt = 0 in RUN.
REQ-030 stall_cnt SHALL increment per stalled CPU cycle, saturate at 16'hFFFF, never wrap.
REQ-031 State transition and grant in the same cycle: grant follows current (pre-transition) state.

Reset
REQ-032 reset = 0 SHALL immediately force: state BOOT, last_owner = loader, pending read owner = none, stall_cnt = 0.
REQ-033 During reset all outputs SHALL be 0 except cpu_hold = 1 and arb_state = 00; pending rvalid dropped.
REQ-034 Reset release SHALL take effect at next rising edge; no grant issued while reset = 0.

Verification
REQ-035 Boot load: ld writes 0x00001002 to addr 0x00, 0x00001312 to 0x01, cpu_req=1 throughout -> cpu_gnt=0, cpu_hold=1, stall_cnt counts, RAM holds both words.
REQ-036 boot_done pulse then ld reads 0x01 -> arb_state 01 next cycle; ld_rvalid=1 one cycle after ld_gnt with ld_rdata=0x00001312.
REQ-037 RUN, both req continuously (reads of 0x00/0x01) -> gnt alternates CPU, LD, CPU, LD; rvalid routed to matching owner each following cycle.
REQ-038 ld_lock=1 with ld_gnt in RUN -> LOCK, cpu_hold=1, CPU starved; ld_lock=0 -> RUN, CPU granted first.
REQ-039 reset=0 asserted mid-read (cycle after cpu_gnt) -> cpu_rvalid=0, arb_state=00, stall_cnt=0 immediately.
REQ-040 Hold cpu_req=1 in LOCK for 70000 cycles -> stall_cnt = 16'hFFFF, stays there.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: boot/run/lock arbiter sharing one single-port RAM between a CPU and a loader
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  boot_done_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_rvalid_o,
  input  logic                  ld_req_i,
  input  logic                  ld_we_i,
  input  logic                  ld_lock_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_wdata_i,
  output logic                  ld_gnt_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic                  ld_rvalid_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  cpu_hold_o,
  output logic [1:0]            arb_state_o,
  output logic [15:0]           stall_cnt_o
);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, LOCK = 2'b10} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  pend_q, pend_d;
  logic [15:0] stall_q, stall_d;
  // Grants, next state, ownership and read tracking; last_q=1 means loader owned the RAM last
  always_comb begin
    cpu_gnt_o = rst_ni & cpu_req_i & (state_q == RUN) & (~ld_req_i | last_q);
    ld_gnt_o  = rst_ni & ld_req_i & ((state_q != RUN) | ~cpu_req_i | ~last_q);
    state_d   = (state_q == BOOT) ? (boot_done_i ? RUN : BOOT) :
                (state_q == RUN)  ? ((ld_gnt_o & ld_lock_i) ? LOCK : RUN) :
                (state_q == LOCK) ? (ld_lock_i ? LOCK : RUN) : BOOT;
    last_d    = cpu_gnt_o ? 1'b0 : (ld_gnt_o | (state_q == LOCK)) ? 1'b1 : last_q;
    pend_d    = {ld_gnt_o & ~ld_we_i, cpu_gnt_o & ~cpu_we_i};
    stall_d   = (cpu_req_i & ~cpu_gnt_o & (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end
  // State registers, cleared immediately by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      last_q  <= 1'b1;
      pend_q  <= 2'b00;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end
  assign ram_en_o     = cpu_gnt_o | ld_gnt_o;
  assign ram_we_o     = cpu_gnt_o ? cpu_we_i : ld_gnt_o & ld_we_i;
  assign ram_addr_o   = cpu_gnt_o ? cpu_addr_i : ld_gnt_o ? ld_addr_i : '0;
  assign ram_wdata_o  = cpu_gnt_o ? cpu_wdata_i : ld_gnt_o ? ld_wdata_i : '0;
  assign cpu_rvalid_o = pend_q[0];
  assign ld_rvalid_o  = pend_q[1];
  assign cpu_rdata_o  = pend_q[0] ? ram_rdata_i : '0;
  assign ld_rdata_o   = pend_q[1] ? ram_rdata_i : '0;
  assign cpu_hold_o   = state_q != RUN;
  assign arb_state_o  = state_q;
  assign stall_cnt_o  = stall_q;
endmodule
